gray_code_unit: RTL and testbench

- Parametrised, registered Gray/binary converter with a valid/ready handshake on both sides.
- Runtime mode selects Gray→binary or binary→Gray conversion.
- Optional step checker flags any pair of consecutive accepted code words whose Gray forms differ in more than one bit.
- Sits between Gray-coded sources (encoders, cross-domain pointers) and binary consumers, or the reverse.

---
 rtl/gray_code_unit.sv | 108 ++++++++++
 tb/tb_gray_code_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/gray_code_unit.sv
// Registered Gray <-> binary converter with valid/ready handshake on both
// sides and an optional Gray step checker that flags multi-bit jumps between
// consecutive accepted words of the same mode.
module gray_code_unit #(
  parameter int WIDTH      = 8,
  parameter bit CHECK_STEP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_step_err
);

  // Prefix-XOR from the MSB down: each binary bit is the parity of all
  // Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // True when more than one bit of d is set: clearing the lowest set bit
  // leaves something behind only if a second bit was set.
  function automatic logic multi_bit(input logic [WIDTH-1:0] d);
    return |(d & (d - WIDTH'(1)));
  endfunction

  // ---- stage p0: input cycle, combinational conversion and step check ----
  logic             accept_p0;
  logic [WIDTH-1:0] conv_p0;
  logic             err_p0;

  // ---- stage p1: output register ----
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             err_p1;

  // Only a stalled, full output register blocks the input; in_valid is not
  // involved so there is no combinational loop through the source.
  assign in_ready  = ~vld_p1 | out_ready;
  assign accept_p0 = in_valid & in_ready;
  assign conv_p0   = mode ? bin_to_gray(in_data) : gray_to_bin(in_data);

  if (CHECK_STEP) begin : g_check
    logic [WIDTH-1:0] curr_gray_p0;
    logic [WIDTH-1:0] prev_gray;
    logic             prev_valid;
    logic             prev_mode;

    // In binary mode the converted word is already the Gray form.
    assign curr_gray_p0 = mode ? conv_p0 : in_data;

    // A mode change exempts the first word of the new mode; repeats and
    // single-bit changes (including wrap-around) are legal.
    assign err_p0 = prev_valid & (mode == prev_mode)
                  & multi_bit(curr_gray_p0 ^ prev_gray);

    // Reference word tracking: every accepted word, errored or not, becomes
    // the new reference.
    always_ff @(posedge clk) begin
      if (rst) begin
        prev_valid <= 1'b0;
        prev_gray  <= '0;
        prev_mode  <= 1'b0;
      end else if (accept_p0) begin
        prev_valid <= 1'b1;
        prev_gray  <= curr_gray_p0;
        prev_mode  <= mode;
      end
    end
  end else begin : g_nocheck
    assign err_p0 = 1'b0;
  end

  // Output register: load on accept, drain on out_ready, hold when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= conv_p0;
      err_p1  <= err_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid    = vld_p1;
  assign out_data     = data_p1;
  assign out_step_err = err_p1;

endmodule

// File: tb/tb_gray_code_unit.sv
// Directed bench for gray_code_unit (WIDTH=4). A checker-enabled and a
// checker-disabled instance share the same stimulus.
module tb_gray_code_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready0, out_valid0, out_step_err0;
  logic [W-1:0] out_data0;
  logic         in_ready1, out_valid1, out_step_err1;
  logic [W-1:0] out_data1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gray_code_unit #(.WIDTH(W), .CHECK_STEP(1'b1)) u_chk (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready0), .in_data(in_data), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_step_err(out_step_err0)
  );

  gray_code_unit #(.WIDTH(W), .CHECK_STEP(1'b0)) u_nochk (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready1), .in_data(in_data), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_step_err(out_step_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word; return #1 after the edge that accepts it.
  task automatic send(input logic m, input logic [W-1:0] d);
    mode     = m;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Expected state of both instances after an accepted word.
  task automatic expect_out(input string tag, input logic [W-1:0] d, input logic e);
    chk({tag, ".valid"},   out_valid0,    1'b1);
    chk({tag, ".data"},    out_data0,     d);
    chk({tag, ".err"},     out_step_err0, e);
    chk({tag, ".nc_data"}, out_data1,     d);
    chk({tag, ".nc_err"},  out_step_err1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", out_valid0, 1'b0);
    chk("rst.data",  out_data0,  4'b0000);
    chk("rst.err",   out_step_err0, 1'b0);
    chk("rst.ready", in_ready0,  1'b1);
    rst = 1'b0;

    // Basic Gray->binary
    send(1'b0, 4'b0110); expect_out("g2b_0110", 4'b0100, 1'b0);
    send(1'b0, 4'b1000); expect_out("g2b_1000", 4'b1111, 1'b1);
    send(1'b0, 4'b0000); expect_out("g2b_0000", 4'b0000, 1'b0);

    // Basic binary->Gray, back to back
    send(1'b1, 4'b1011); expect_out("b2g_1011", 4'b1110, 1'b0);
    send(1'b1, 4'b1111); expect_out("b2g_1111", 4'b1000, 1'b1);

    // Full-cycle walk in Gray, then wrap
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] b;
      b = W'(i);
      send(1'b0, b ^ (b >> 1));
      expect_out($sformatf("walk_%0d", i), b, 1'b0);
    end
    send(1'b0, 4'b0000); expect_out("wrap", 4'b0000, 1'b0);
    send(1'b0, 4'b0001); expect_out("walk_a", 4'b0001, 1'b0);
    send(1'b0, 4'b0011); expect_out("rep_1", 4'b0010, 1'b0);
    send(1'b0, 4'b0011); expect_out("rep_2", 4'b0010, 1'b0);

    // Step error after a reset
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(1'b0, 4'b0000); expect_out("se_0000", 4'b0000, 1'b0);
    send(1'b0, 4'b0011); expect_out("se_0011", 4'b0010, 1'b1);
    send(1'b0, 4'b0001); expect_out("se_0001", 4'b0001, 1'b0);

    // Mode-change exemption
    send(1'b1, 4'b0000); expect_out("mc_b0000", 4'b0000, 1'b0);
    send(1'b0, 4'b1111); expect_out("mc_g1111", 4'b1010, 1'b0);
    send(1'b0, 4'b0000); expect_out("jump_0000", 4'b0000, 1'b1);
    send(1'b0, 4'b0011); expect_out("jump_0011", 4'b0010, 1'b1);

    // Drain: valid drops, data holds
    idle();
    chk("drain.valid", out_valid0, 1'b0);
    chk("drain.data",  out_data0,  4'b0010);
    chk("drain.ready", in_ready0,  1'b1);

    // Backpressure
    send(1'b0, 4'b0110); expect_out("bp_0110", 4'b0100, 1'b1);
    out_ready = 1'b0;
    mode      = 1'b0;
    in_data   = 4'b1111;
    #1;
    chk("bp.ready", in_ready0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.valid", c), out_valid0, 1'b1);
      chk($sformatf("bp%0d.data",  c), out_data0,  4'b0100);
      chk($sformatf("bp%0d.err",   c), out_step_err0, 1'b1);
      chk($sformatf("bp%0d.ready", c), in_ready0,  1'b0);
    end

    // Reset with a held word and a pending input
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2.valid", out_valid0, 1'b0);
    chk("rst2.data",  out_data0,  4'b0000);
    chk("rst2.err",   out_step_err0, 1'b0);
    chk("rst2.ready", in_ready0,  1'b1);
    rst       = 1'b0;
    out_ready = 1'b1;
    send(1'b0, 4'b0011); expect_out("post_rst", 4'b0010, 1'b0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
